// File: rtl/bcd_serial_addsub_pkg.sv
// Shared types and digit helpers for the serial BCD adder/subtractor.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // 9 - d; only meaningful for d <= 9, which validation guarantees.
    function automatic logic [3:0] nines_comp(input logic [3:0] d);
        return BCD_MAX - d;
    endfunction

    function automatic logic bcd_valid(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Operand/result bundle between the requester and the serial BCD unit.
// Latency: none (wires only).
// Backpressure: start is only honoured while busy is low.
interface bcd_serial_addsub_if #(parameter int DIGITS = 4);
    logic                  start;
    logic                  sub;
    logic [4*DIGITS-1:0]   x;
    logic [4*DIGITS-1:0]   y;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   z;
    logic                  co;
    logic                  neg;
    logic                  err;

    modport master (output start, sub, x, y,
                    input  busy, done, z, co, neg, err);
    modport slave  (input  start, sub, x, y,
                    output busy, done, z, co, neg, err);
endinterface

// File: rtl/bcd_serial_addsub_bcdadd.sv
// Single-digit BCD adder: s = a + b + ci with decimal carry out.
// Latency: combinational.
// Backpressure: none.
module BCDadd (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] raw;
    logic [4:0] adj;

    // Binary sum, then +6 correction when the digit exceeds 9.
    always_comb begin
        raw = {1'b0, a} + {1'b0, b} + {4'd0, ci};
        adj = raw + 5'd6;
        co  = 1'b0;
        s   = raw[3:0];
        if (raw > 5'd9) begin
            co = 1'b1;
            s  = adj[3:0];
        end
    end
endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit BCD add/sub, one digit per clock LSD first, sign-magnitude result.
// Latency: DIGITS+1 (add / non-negative sub), 2*DIGITS+1 (negative sub), 1 (bad digit).
// Backpressure: start ignored while busy; done pulses one cycle, z held until next start.
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_serial_addsub_if.slave   bus
);
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    state_t              state, state_nx;
    logic [4*DIGITS-1:0] x_q, y_q, z_q;
    logic                sub_q, carry_q;
    logic [CW-1:0]       idx;
    logic                co_q, neg_q, err_q;

    logic                in_bad;
    logic                last;
    logic [3:0]          da, db, dsum;
    logic                dci, dco;

    assign last = (idx == LAST);

    // Any non-decimal digit in the presented operands.
    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_valid(bus.x[4*i +: 4]) || !bcd_valid(bus.y[4*i +: 4]))
                in_bad = 1'b1;
        end
    end

    // Operand steering for the shared digit adder: ADD pass or 0 - z fix-up pass.
    always_comb begin
        da  = 4'd0;
        db  = 4'd0;
        dci = 1'b0;
        if (state == FIX) begin
            db  = nines_comp(z_q[4*idx +: 4]);
            dci = (idx == '0) ? 1'b1 : carry_q;
        end else begin
            da  = x_q[4*idx +: 4];
            db  = sub_q ? nines_comp(y_q[4*idx +: 4]) : y_q[4*idx +: 4];
            dci = (idx == '0) ? sub_q : carry_q;
        end
    end

    BCDadd u_bcdadd (
        .a  (da),
        .b  (db),
        .ci (dci),
        .s  (dsum),
        .co (dco)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state: a borrow out of the last digit on sub sends us through FIX.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start) state_nx = in_bad ? DONE : ADD;
            ADD:  if (last)      state_nx = (sub_q && !dco) ? FIX : DONE;
            FIX:  if (last)      state_nx = DONE;
            DONE:                state_nx = IDLE;
            default:             state_nx = IDLE;
        endcase
    end

    // Operand latch, digit counter, result and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx     <= '0;
            co_q    <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    x_q     <= bus.x;
                    y_q     <= bus.y;
                    sub_q   <= bus.sub;
                    z_q     <= '0;
                    co_q    <= 1'b0;
                    neg_q   <= 1'b0;
                    err_q   <= in_bad;
                    carry_q <= 1'b0;
                    idx     <= '0;
                end
                ADD: begin
                    z_q[4*idx +: 4] <= dsum;
                    carry_q         <= dco;
                    if (last) begin
                        idx <= '0;
                        if (!sub_q)   co_q  <= dco;
                        else if (!dco) neg_q <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                FIX: begin
                    z_q[4*idx +: 4] <= dsum;
                    carry_q         <= dco;
                    idx             <= last ? '0 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.z    = z_q;
    assign bus.co   = co_q;
    assign bus.neg  = neg_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub with hand-computed expectations.
// Latency: checks done-cycle count from the accepting edge.
// Backpressure: exercises start held high while busy and in the done cycle.
module tb_bcd_serial_addsub;
    localparam int DIGITS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    bcd_serial_addsub_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Issue one operation and wait (bounded) for done; n counts edges from the accepting one.
    task automatic run_op(input string tag, input logic s, input logic [15:0] xv, input logic [15:0] yv,
                          input int exp_lat, input logic [15:0] exp_z,
                          input logic exp_co, input logic exp_neg, input logic exp_err);
        int  n;
        logic seen;
        @(negedge clk);
        bus.start = 1'b1; bus.sub = s; bus.x = xv; bus.y = yv;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); n++; #1;
            bus.start = 1'b0;
            if (bus.done) seen = 1'b1;
        end
        check({tag, " lat"}, n, exp_lat);
        check({tag, " z"},   bus.z, exp_z);
        check({tag, " co"},  bus.co, exp_co);
        check({tag, " neg"}, bus.neg, exp_neg);
        check({tag, " err"}, bus.err, exp_err);
        @(posedge clk); #1;
        check({tag, " done drop"}, {bus.done, bus.busy}, 2'b00);
    endtask

    initial begin
        int  n;
        logic seen;
        bus.start = 1'b0; bus.sub = 1'b0; bus.x = '0; bus.y = '0;
        #1;
        check("reset outs", {bus.busy, bus.done, bus.co, bus.neg, bus.err}, 5'b0);
        check("reset z", bus.z, 16'h0000);
        #20 rst = 1'b0;

        run_op("add 1234+8766", 1'b0, 16'h1234, 16'h8766, 5, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op("sub 5000-1234", 1'b1, 16'h5000, 16'h1234, 5, 16'h3766, 1'b0, 1'b0, 1'b0);
        run_op("sub 1234-5000", 1'b1, 16'h1234, 16'h5000, 9, 16'h3766, 1'b0, 1'b1, 1'b0);
        run_op("sub 0042-0042", 1'b1, 16'h0042, 16'h0042, 5, 16'h0000, 1'b0, 1'b0, 1'b0);
        run_op("err 12A4",      1'b0, 16'h12A4, 16'h0001, 1, 16'h0000, 1'b0, 1'b0, 1'b1);
        run_op("add 0999+0001", 1'b0, 16'h0999, 16'h0001, 5, 16'h1000, 1'b0, 1'b0, 1'b0);
        run_op("add 9999+0001", 1'b0, 16'h9999, 16'h0001, 5, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op("sub 0100-0001", 1'b1, 16'h0100, 16'h0001, 5, 16'h0099, 1'b0, 1'b0, 1'b0);

        // start held high with changing operands: only the first is taken.
        @(negedge clk);
        bus.start = 1'b1; bus.sub = 1'b0; bus.x = 16'h0001; bus.y = 16'h0002;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); n++; #1;
            bus.x = 16'h0555 + 16'(n); bus.y = 16'h0444;
            if (bus.done) seen = 1'b1;
        end
        check("hold lat", n, 5);
        check("hold z", bus.z, 16'h0003);
        bus.x = 16'h0002; bus.y = 16'h0002;
        @(posedge clk); #1;
        check("start in done ignored", bus.busy, 1'b0);
        @(posedge clk); #1;
        check("start after done taken", bus.busy, 1'b1);
        bus.start = 1'b0;
        n = 1; seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); n++; #1;
            if (bus.done) seen = 1'b1;
        end
        check("hold2 lat", n, 5);
        check("hold2 z", bus.z, 16'h0004);
        @(posedge clk); #1;

        // Reset during the third ADD cycle abandons the operation.
        @(negedge clk);
        bus.start = 1'b1; bus.sub = 1'b0; bus.x = 16'h1111; bus.y = 16'h2222;
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre-rst partial z", bus.z, 16'h0033);
        #1 rst = 1'b1;
        #1;
        check("async rst outs", {bus.busy, bus.done, bus.co, bus.neg, bus.err}, 5'b0);
        check("async rst z", bus.z, 16'h0000);
        #10 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1'b1;
        end
        check("no done after rst", seen, 1'b0);
        run_op("add 0005+0005", 1'b0, 16'h0005, 16'h0005, 5, 16'h0010, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
Multi-digit BCD adder/subtractor that time-shares the team's single-digit BCD adder (BCDadd) and feeds it one digit per clock, least significant digit first.
Subtraction uses nine's complement plus carry-in. A negative difference gets a second serial ten's-complement pass, so the result is sign-magnitude.
Sits between operand registers and the display/ALU front-end. Uses a start/busy/done handshake.

Parameters:
DIGITS, 4, number of BCD digits per operand (≥1); operand width is 4*DIGITS.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  request; accepted only when busy=0
sub  in  1  sampled with start: 0 = x+y, 1 = x−y
x  in  4*DIGITS  BCD operand, sampled with start
y  in  4*DIGITS  BCD operand, sampled with start
busy  out  1  high while operation in progress (states ADD, FIX, DONE)
done  out  1  one-cycle pulse, result valid
z  out  4*DIGITS  BCD magnitude result, held until next accepted start
co  out  1  add: decimal overflow (carry out of top digit); sub: 0
neg  out  1  sub: result negative; add: 0
err  out  1  a sampled operand held a digit >9

Behaviour:
- Reset: asynchronous; state IDLE; busy, done, co, neg, err = 0; z = 0; internal operand/digit-counter registers = 0. Reset mid-operation abandons it with no done pulse.
- Start acceptance:
  - start=1 in IDLE latches x, y, sub; clears z, co, neg, err.
  - start while busy=1 is ignored; latched operands are unaffected.
- Operand validation at acceptance: if any digit of x or y >9, go to DONE next cycle with err=1 and z=0. Latency is 1 cycle from start to done.
- States:
  - IDLE: waits for start.
  - ADD: one digit per cycle. Index i runs 0..DIGITS-1. Adder inputs: x digit i, and y digit i or its nine's complement (9−d) when sub=1.
    - Carry-in at i=0 is sub; after that it is the registered carry.
    - Digit result is written to z[4i+3:4i]; carry is registered.
  - After the last ADD digit:
    - add: co = final carry, go to DONE.
    - sub with final carry=1: result ≥0, neg=0, go to DONE.
    - sub with final carry=0: result negative, neg=1, go to FIX.
  - FIX: DIGITS cycles. Adder inputs: digit 0 and nine's complement of z digit i; carry-in 1 at i=0. This computes 0−z (ten's complement). The result overwrites z digit i and the final carry is discarded.
  - DONE: done=1 for exactly one cycle; next state IDLE; busy drops to 0 in IDLE.
- Latency from the start edge to the done cycle: add, or non-negative sub: DIGITS+1 cycles; negative sub: 2*DIGITS+1 cycles; err: 1 cycle.
- Boundary cases:
  - x−x gives z=0, neg=0 (final carry is 1).
  - Maximum add wraps: 9999+0001 gives z=0000, co=1.
  - The digit counter wraps to 0 when leaving ADD and when leaving FIX.
  - start asserted in the DONE cycle is ignored; start in the following IDLE cycle is accepted.
- Only a single BCDadd instance exists; no combinational path from inputs to outputs.

Decomposition:
- Package bcd_pkg holds:
  - state enum (IDLE, ADD, FIX, DONE);
  - constant BCD_MAX=9;
  - function nines_comp(4-bit) returning 9−d;
  - function bcd_valid(4-bit).
- One sub-module: the existing BCDadd, instantiated once as the shared digit datapath. The counter and FSM stay in this module.

Test Plan:
- add x=1234 y=8766 -> z=0000, co=1, neg=0, err=0; done exactly 5 cycles after start.
- sub x=5000 y=1234 -> z=3766, neg=0, co=0; done at cycle 5.
- sub x=1234 y=5000 -> z=3766, neg=1; done at cycle 9. Also sub x=0042 y=0042 -> z=0000, neg=0; done at cycle 5.
- add x=12A4 y=0001 -> err=1, z=0000; done at cycle 1. Next add x=0999 y=0001 clears err, gives z=1000, co=0.
- start=1 held continuously with changing operands during a busy add -> only the first operation is performed; result matches the first operands; the next start is accepted the cycle after done.
- rst pulsed during the 3rd ADD cycle -> busy, done, z, co, neg, err go to 0 without waiting for a clock edge; no done pulse follows. A start after rst release completes normally (0005+0005 -> 0010).
